video_delay_line_ctl: RTL and testbench

//  Parametrised AXI4-Stream video delay line with full backpressure and a run-time selectable delay.

---
 rtl/video_delay_line_ctl.sv | 98 +++++++++
 tb/tb_video_delay_line_ctl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_delay_line_ctl.sv
// video_delay_line_ctl: AXI4-Stream video delay line with run-time delay, switched only at SOF after draining.
module video_delay_line_ctl #(
    parameter int MAX_DELAY = 16,
    parameter int DEFAULT_DELAY = 1,
    parameter int COLOR_WIDTH = 8,
    parameter int NUM_CHANNELS = 3,
    localparam int TW = NUM_CHANNELS * COLOR_WIDTH,
    localparam int DW = $clog2(MAX_DELAY + 1)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic [DW-1:0] cfg_delay,
    input  logic [TW-1:0] video_in_tdata,
    input  logic          video_in_tlast,
    input  logic          video_in_tuser,
    input  logic          video_in_tvalid,
    output logic          video_in_tready,
    output logic [TW-1:0] video_out_tdata,
    output logic          video_out_tlast,
    output logic          video_out_tuser,
    output logic          video_out_tvalid,
    input  logic          video_out_tready,
    output logic [DW-1:0] stat_active_delay,
    output logic [DW-1:0] stat_occupancy,
    output logic          stat_draining,
    output logic [15:0]   stat_frames
);
    typedef enum logic {RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [DW-1:0] active_delay, cfg_clamped, occ, tap;
    logic ce, hold, byp, pass, run, in_hs, out_hs, switch_now;
    logic [MAX_DELAY:1] s_valid, s_last, s_user;
    logic [TW-1:0] s_data [1:MAX_DELAY];
    logic [15:0] frames;

    assign cfg_clamped = (cfg_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_delay;
    assign byp = active_delay == '0;
    assign tap = byp ? DW'(1) : active_delay;
    assign run = state == RUN;
    assign hold = video_in_tvalid & video_in_tuser & (cfg_clamped != active_delay);
    // In reset the bypass path falls back to the cleared stages so all outputs read 0
    assign pass = byp & aresetn;
    assign video_out_tvalid = pass ? (video_in_tvalid & run & ~hold) : s_valid[tap];
    assign video_out_tdata = pass ? video_in_tdata : s_data[tap];
    assign video_out_tlast = pass ? video_in_tlast : s_last[tap];
    assign video_out_tuser = pass ? video_in_tuser : s_user[tap];
    assign ce = video_out_tready | ~video_out_tvalid;
    assign video_in_tready = aresetn & run & ~hold & (byp ? video_out_tready : ce);
    assign in_hs = video_in_tvalid & video_in_tready;
    assign out_hs = video_out_tvalid & video_out_tready;
    assign switch_now = (state == DRAIN) && (occ == '0);

    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) state <= RUN;
        else state <= state_nx;

    always_comb begin
        state_nx = switch_now ? RUN : (run & hold) ? DRAIN : state;
    end

    // Every beat left in the stages at a switch was already output, so all valids are dropped
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) begin
            s_valid <= '0;
            s_last <= '0;
            s_user <= '0;
            for (int i = 1; i <= MAX_DELAY; i++) s_data[i] <= '0;
        end else if (switch_now) begin
            s_valid <= '0;
        end else if (ce) begin
            s_valid[1] <= in_hs;
            s_data[1] <= video_in_tdata;
            s_last[1] <= video_in_tlast;
            s_user[1] <= video_in_tuser;
            for (int i = 2; i <= MAX_DELAY; i++) begin
                s_valid[i] <= s_valid[i-1];
                s_data[i] <= s_data[i-1];
                s_last[i] <= s_last[i-1];
                s_user[i] <= s_user[i-1];
            end
        end

    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) begin
            occ <= '0;
            frames <= '0;
            active_delay <= DW'(DEFAULT_DELAY);
        end else begin
            occ <= occ + DW'(in_hs) - DW'(out_hs);
            if (out_hs & video_out_tuser) frames <= frames + 16'd1;
            if (switch_now) active_delay <= cfg_clamped;
        end

    assign stat_active_delay = active_delay;
    assign stat_occupancy = occ;
    assign stat_draining = state == DRAIN;
    assign stat_frames = frames;
endmodule

// File: tb/tb_video_delay_line_ctl.sv
// tb_video_delay_line_ctl: directed bench for video_delay_line_ctl with a beat scoreboard on the output.
module tb_video_delay_line_ctl;
    logic clk, aresetn;
    logic [4:0] cfg_delay;
    logic [23:0] video_in_tdata, video_out_tdata;
    logic video_in_tlast, video_in_tuser, video_in_tvalid, video_in_tready;
    logic video_out_tlast, video_out_tuser, video_out_tvalid, video_out_tready;
    logic [4:0] stat_active_delay, stat_occupancy;
    logic stat_draining;
    logic [15:0] stat_frames;
    int n_cmp = 0, n_err = 0;
    logic [25:0] exp_q[$];
    logic acc;

    video_delay_line_ctl dut (
        .clk(clk), .aresetn(aresetn), .cfg_delay(cfg_delay),
        .video_in_tdata(video_in_tdata), .video_in_tlast(video_in_tlast),
        .video_in_tuser(video_in_tuser), .video_in_tvalid(video_in_tvalid),
        .video_in_tready(video_in_tready),
        .video_out_tdata(video_out_tdata), .video_out_tlast(video_out_tlast),
        .video_out_tuser(video_out_tuser), .video_out_tvalid(video_out_tvalid),
        .video_out_tready(video_out_tready),
        .stat_active_delay(stat_active_delay), .stat_occupancy(stat_occupancy),
        .stat_draining(stat_draining), .stat_frames(stat_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Evaluates handshakes before the edge, then advances to 1 time unit past the next edge
    task automatic tick();
        logic [25:0] e;
        #1;
        acc = video_in_tvalid && video_in_tready;
        if (acc) exp_q.push_back({video_in_tuser, video_in_tlast, video_in_tdata});
        if (video_out_tvalid && video_out_tready) begin
            if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("beat", {video_out_tuser, video_out_tlast, video_out_tdata}, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream(int n, logic [23:0] base, bit toggle, int maxocc);
        int sent = 0;
        int cyc = 0;
        while ((sent < n || exp_q.size() > 0) && cyc < 400) begin
            video_in_tvalid = sent < n;
            video_in_tdata = base + 24'(sent);
            video_in_tuser = sent == 0;
            video_in_tlast = sent == n - 1;
            video_out_tready = toggle ? cyc[0] : 1'b1;
            chk("occ_max", 32'(stat_occupancy <= 5'(maxocc)), 1);
            tick();
            if (acc) sent++;
            cyc++;
        end
        video_in_tvalid = 1'b0;
        video_out_tready = 1'b1;
        chk("stream_sent", sent, n);
        chk("stream_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int blocked, lat;
        bit drained;
        aresetn = 1'b0;
        cfg_delay = 5'd1;
        video_in_tdata = '0;
        video_in_tlast = 1'b0;
        video_in_tuser = 1'b0;
        video_in_tvalid = 1'b1;
        video_out_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", video_out_tvalid, 0);
        chk("rst_out_data", video_out_tdata, 0);
        chk("rst_in_ready", video_in_tready, 0);
        chk("rst_active", stat_active_delay, 1);
        chk("rst_occ", stat_occupancy, 0);
        chk("rst_frames", stat_frames, 0);
        chk("rst_draining", stat_draining, 0);
        aresetn = 1'b1;
        video_in_tvalid = 1'b0;
        @(posedge clk);
        #1;

        // 1: D=1, one line of 8 pixels, each out one cycle after accept
        for (int k = 1; k <= 8; k++) begin
            video_in_tvalid = 1'b1;
            video_in_tdata = 24'(k);
            video_in_tuser = k == 1;
            video_in_tlast = k == 8;
            #1;
            chk("t1_in_ready", video_in_tready, 1);
            tick();
            chk("t1_out_valid", video_out_tvalid, 1);
            chk("t1_out_data", video_out_tdata, k);
            chk("t1_out_last", video_out_tlast, k == 8);
            chk("t1_occ", stat_occupancy, 1);
        end
        video_in_tvalid = 1'b0;
        tick();
        chk("t1_frames", stat_frames, 1);
        chk("t1_occ_end", stat_occupancy, 0);

        // 2: D=4 with output ready toggling
        cfg_delay = 5'd4;
        stream(8, 24'h100, 1'b1, 4);
        chk("t2_active", stat_active_delay, 4);

        // 3: D=3, request 7 mid-frame; switch waits for the next SOF and a full drain
        cfg_delay = 5'd3;
        stream(4, 24'h200, 1'b0, 4);
        chk("t3_active3", stat_active_delay, 3);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) cfg_delay = 5'd7;
            video_in_tvalid = 1'b1;
            video_in_tdata = 24'h210 + 24'(k);
            video_in_tuser = k == 0;
            video_in_tlast = k == 5;
            #1;
            chk("t3_b_ready", video_in_tready, 1);
            tick();
        end
        chk("t3_active_kept", stat_active_delay, 3);
        video_in_tdata = 24'h300;
        video_in_tuser = 1'b1;
        video_in_tlast = 1'b1;
        #1;
        blocked = 0;
        drained = 1'b0;
        while (!video_in_tready && blocked < 20) begin
            tick();
            drained |= stat_draining;
            blocked++;
        end
        chk("t3_blocked_cycles", blocked, 4);
        chk("t3_drain_seen", drained, 1);
        chk("t3_occ_switch", stat_occupancy, 0);
        chk("t3_active7", stat_active_delay, 7);
        tick();
        chk("t3_sof_accepted", acc, 1);
        video_in_tvalid = 1'b0;
        lat = 1;
        while (!(video_out_tvalid && video_out_tdata == 24'h300) && lat < 20) begin
            tick();
            lat++;
        end
        chk("t3_sof_latency", lat, 7);
        tick();
        chk("t3_queue_empty", exp_q.size(), 0);
        chk("t3_frames", stat_frames, 5);

        // 4: bypass
        cfg_delay = 5'd0;
        stream(3, 24'h400, 1'b0, 7);
        chk("t4_active0", stat_active_delay, 0);
        video_in_tvalid = 1'b1;
        video_in_tdata = 24'h5A5A5A;
        video_in_tuser = 1'b0;
        video_in_tlast = 1'b0;
        video_out_tready = 1'b1;
        #1;
        chk("t4_pass_data", video_out_tdata, 24'h5A5A5A);
        chk("t4_pass_valid", video_out_tvalid, 1);
        chk("t4_ready_hi", video_in_tready, 1);
        video_out_tready = 1'b0;
        #1;
        chk("t4_ready_lo", video_in_tready, 0);
        video_out_tready = 1'b1;
        #1;
        chk("t4_ready_back", video_in_tready, 1);
        tick();
        video_in_tvalid = 1'b0;

        // 5: out-of-range request clamps
        cfg_delay = 5'd21;
        stream(3, 24'h500, 1'b0, 16);
        chk("t5_active_clamp", stat_active_delay, 16);
        chk("t5_frames", stat_frames, 7);

        // 6: reset mid-frame with 5 beats in flight
        for (int k = 0; k < 5; k++) begin
            video_in_tvalid = 1'b1;
            video_in_tdata = 24'h600 + 24'(k);
            video_in_tuser = k == 0;
            video_in_tlast = 1'b0;
            tick();
        end
        chk("t6_occ5", stat_occupancy, 5);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_out_valid", video_out_tvalid, 0);
        chk("t6_out_data", video_out_tdata, 0);
        chk("t6_out_user", video_out_tuser, 0);
        chk("t6_in_ready", video_in_tready, 0);
        chk("t6_occ", stat_occupancy, 0);
        chk("t6_active", stat_active_delay, 1);
        chk("t6_frames", stat_frames, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        video_in_tvalid = 1'b0;
        cfg_delay = 5'd1;
        stream(4, 24'h700, 1'b1, 1);
        chk("t6_frames_after", stat_frames, 1);
        chk("t6_active_after", stat_active_delay, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
